// File: rtl/ps2_kbd_pkg.sv
// Shared constants, decoder state encoding and glyph / scan-code lookup helpers
// for the PS/2 keyboard display block.
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;

  // Active-low glyphs, bit7=a .. bit1=g, bit0=dp (always dark).
  function automatic logic [7:0] hex2seg(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0:    g = 8'h03;
      4'h1:    g = 8'h9F;
      4'h2:    g = 8'h25;
      4'h3:    g = 8'h0D;
      4'h4:    g = 8'h99;
      4'h5:    g = 8'h49;
      4'h6:    g = 8'h41;
      4'h7:    g = 8'h1F;
      4'h8:    g = 8'h01;
      4'h9:    g = 8'h09;
      4'hA:    g = 8'h11;
      4'hB:    g = 8'hC1;
      4'hC:    g = 8'h63;
      4'hD:    g = 8'h85;
      4'hE:    g = 8'h61;
      default: g = 8'h71;
    endcase
    return g;
  endfunction

  // Returns {valid, ascii}; only letters and digits of scan-code set 2 are mapped.
  function automatic logic [8:0] scan2ascii(input logic [7:0] code);
    logic [8:0] r;
    case (code)
      8'h1C: r = {1'b1, 8'h41};
      8'h32: r = {1'b1, 8'h42};
      8'h21: r = {1'b1, 8'h43};
      8'h23: r = {1'b1, 8'h44};
      8'h24: r = {1'b1, 8'h45};
      8'h2B: r = {1'b1, 8'h46};
      8'h34: r = {1'b1, 8'h47};
      8'h33: r = {1'b1, 8'h48};
      8'h43: r = {1'b1, 8'h49};
      8'h3B: r = {1'b1, 8'h4A};
      8'h42: r = {1'b1, 8'h4B};
      8'h4B: r = {1'b1, 8'h4C};
      8'h3A: r = {1'b1, 8'h4D};
      8'h31: r = {1'b1, 8'h4E};
      8'h44: r = {1'b1, 8'h4F};
      8'h4D: r = {1'b1, 8'h50};
      8'h15: r = {1'b1, 8'h51};
      8'h2D: r = {1'b1, 8'h52};
      8'h1B: r = {1'b1, 8'h53};
      8'h2C: r = {1'b1, 8'h54};
      8'h3C: r = {1'b1, 8'h55};
      8'h2A: r = {1'b1, 8'h56};
      8'h1D: r = {1'b1, 8'h57};
      8'h22: r = {1'b1, 8'h58};
      8'h35: r = {1'b1, 8'h59};
      8'h1A: r = {1'b1, 8'h5A};
      8'h45: r = {1'b1, 8'h30};
      8'h16: r = {1'b1, 8'h31};
      8'h1E: r = {1'b1, 8'h32};
      8'h26: r = {1'b1, 8'h33};
      8'h25: r = {1'b1, 8'h34};
      8'h2E: r = {1'b1, 8'h35};
      8'h36: r = {1'b1, 8'h36};
      8'h3D: r = {1'b1, 8'h37};
      8'h3E: r = {1'b1, 8'h38};
      8'h46: r = {1'b1, 8'h39};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_kbd_display_if.sv
// PS/2 line inputs and board display outputs of the keyboard block.
// master = board/device side driving the PS/2 lines, slave = the keyboard block.
interface ps2_kbd_display_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] ledr;
  logic [7:0]  seg0;
  logic [7:0]  seg1;
  logic [7:0]  seg2;
  logic [7:0]  seg3;
  logic [7:0]  seg4;
  logic [7:0]  seg5;
  logic [7:0]  seg6;
  logic [7:0]  seg7;

  modport master (
    output ps2_clk, ps2_data,
    input  ledr, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output ledr, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: 3-flop sync, falling-edge sampling, framing/odd-parity check, idle timeout.
// code_stb/err_stb pulse one clk after the 11th synced falling edge; no back-pressure.
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_stb,
  output logic       err_stb
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    clk_sync;
  logic [2:0]    data_sync;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic [TW-1:0] idle_cnt;
  logic          fall;
  logic [10:0]   frame;
  logic          frame_ok;

  assign fall     = (clk_sync[2:1] == 2'b10);
  // Complete frame as seen on the 11th edge: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign frame    = {data_sync[2], shift};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
      bit_cnt   <= '0;
      shift     <= '0;
      idle_cnt  <= '0;
      code      <= '0;
      code_stb  <= 1'b0;
      err_stb   <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
      code_stb  <= 1'b0;
      err_stb   <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        shift    <= {data_sync[2], shift[9:1]};
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            code     <= frame[8:1];
            code_stb <= 1'b1;
          end else begin
            err_stb  <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == IDLE_LAST) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_display.sv
// PS/2 keyboard front end: make/break/extended decoding, press counter, 7-segment and LED display.
// Display settles one clk after code_stb; codes are consumed every frame with no back-pressure.
module ps2_kbd_display
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              resetn,
  ps2_kbd_display_if.slave  bus
);

  logic [7:0]      code;
  logic            code_stb;
  logic            err_stb;

  dec_state_t      state, state_n;
  logic            held, held_n;
  logic [7:0]      last_code, last_code_n;
  logic            ext_seen, ext_seen_n;
  logic [7:0]      count, count_n;
  logic            err;
  logic [5:0][7:0] seg_q, seg_n;
  logic [8:0]      ascii;
  logic            brk_pending;
  logic            ext_pending;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk      (clk),
    .resetn   (resetn),
    .ps2_clk  (bus.ps2_clk),
    .ps2_data (bus.ps2_data),
    .code     (code),
    .code_stb (code_stb),
    .err_stb  (err_stb)
  );

  assign brk_pending = (state == DEC_BRK) || (state == DEC_EXT_BRK);
  assign ext_pending = (state == DEC_EXT) || (state == DEC_EXT_BRK);

  always_comb begin
    state_n     = state;
    held_n      = held;
    last_code_n = last_code;
    ext_seen_n  = ext_seen;
    count_n     = count;
    if (code_stb) begin
      if (code == PS2_EXT) begin
        state_n = brk_pending ? DEC_EXT_BRK : DEC_EXT;
      end else if (code == PS2_BREAK) begin
        state_n = ext_pending ? DEC_EXT_BRK : DEC_BRK;
      end else if (brk_pending) begin
        held_n  = 1'b0;
        state_n = DEC_IDLE;
      end else begin
        // Typematic repeats of the held key do not count as new presses.
        if (!held || (code != last_code)) begin
          count_n = count + 8'd1;
        end
        last_code_n = code;
        ext_seen_n  = ext_pending;
        held_n      = 1'b1;
        state_n     = DEC_IDLE;
      end
    end
  end

  always_comb begin
    ascii    = scan2ascii(last_code_n);
    seg_n[0] = held_n ? hex2seg(last_code_n[3:0]) : SEG_BLANK;
    seg_n[1] = held_n ? hex2seg(last_code_n[7:4]) : SEG_BLANK;
    seg_n[2] = (held_n && ascii[8]) ? hex2seg(ascii[3:0]) : SEG_BLANK;
    seg_n[3] = (held_n && ascii[8]) ? hex2seg(ascii[7:4]) : SEG_BLANK;
    seg_n[4] = hex2seg(count_n[3:0]);
    seg_n[5] = hex2seg(count_n[7:4]);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= DEC_IDLE;
      held      <= 1'b0;
      last_code <= '0;
      ext_seen  <= 1'b0;
      count     <= '0;
      err       <= 1'b0;
      seg_q     <= {6{SEG_BLANK}};
    end else begin
      state     <= state_n;
      held      <= held_n;
      last_code <= last_code_n;
      ext_seen  <= ext_seen_n;
      count     <= count_n;
      err       <= err | err_stb;
      seg_q     <= seg_n;
    end
  end

  assign bus.ledr = {5'b0, err, ext_seen, held, last_code};
  assign bus.seg0 = seg_q[0];
  assign bus.seg1 = seg_q[1];
  assign bus.seg2 = seg_q[2];
  assign bus.seg3 = seg_q[3];
  assign bus.seg4 = seg_q[4];
  assign bus.seg5 = seg_q[5];
  assign bus.seg6 = SEG_BLANK;
  assign bus.seg7 = SEG_BLANK;

endmodule

// File: tb/tb_ps2_kbd_display.sv
// Bench for ps2_kbd_display: directed vector table, reset/timeout/wrap sequences,
// and randomized key streams compared against a behavioural keyboard model.
module tb_ps2_kbd_display;

  localparam int TO = 100;

  typedef struct {
    logic [7:0]  code;
    bit          bad;
    logic [15:0] ledr;
    logic [63:0] seg;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  ps2_kbd_display_if bus ();

  ps2_kbd_display #(.TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] glyph [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                             8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  // Set-2 codes for A..Z then 0..9.
  logic [7:0] key_code [36] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
                                8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] rnd_pool [8] = '{8'h1C, 8'h32, 8'h45, 8'h16, 8'h75, 8'h66, 8'h1A, 8'h46};

  // Keyboard model state
  bit         m_err, m_held, m_ext, m_pext, m_pbrk;
  logic [7:0] m_code;
  int         m_cnt;

  function automatic logic [15:0] exp_ledr();
    return {5'b0, m_err, m_ext, m_held, m_code};
  endfunction

  function automatic logic [63:0] exp_seg();
    logic [7:0] s [8];
    int a;
    for (int i = 0; i < 8; i++) s[i] = 8'hFF;
    if (m_held) begin
      s[0] = glyph[m_code % 16];
      s[1] = glyph[m_code / 16];
      for (int i = 0; i < 36; i++) begin
        if (key_code[i] == m_code) begin
          a = (i < 26) ? (65 + i) : (48 + i - 26);
          s[2] = glyph[a % 16];
          s[3] = glyph[a / 16];
        end
      end
    end
    s[4] = glyph[m_cnt % 16];
    s[5] = glyph[m_cnt / 16];
    return {s[7], s[6], s[5], s[4], s[3], s[2], s[1], s[0]};
  endfunction

  function automatic logic [63:0] dut_seg();
    return {bus.seg7, bus.seg6, bus.seg5, bus.seg4, bus.seg3, bus.seg2, bus.seg1, bus.seg0};
  endfunction

  function automatic logic [10:0] mk_frame(logic [7:0] c, bit bad);
    logic p;
    p = (^c) ? 1'b0 : 1'b1;
    if (bad) p = ~p;
    return {1'b1, p, c, 1'b0};
  endfunction

  task automatic model_reset();
    m_err = 0; m_held = 0; m_ext = 0; m_pext = 0; m_pbrk = 0; m_code = 8'h00; m_cnt = 0;
  endtask

  task automatic model_apply(logic [7:0] c, bit bad);
    if (bad) m_err = 1;
    else if (c == 8'hE0) m_pext = 1;
    else if (c == 8'hF0) m_pbrk = 1;
    else if (m_pbrk) begin
      m_held = 0; m_pbrk = 0; m_pext = 0;
    end else begin
      if (!m_held || c != m_code) m_cnt = (m_cnt + 1) % 256;
      m_code = c; m_ext = m_pext; m_held = 1; m_pext = 0;
    end
  endtask

  task automatic check_val(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(string name);
    check_val({name, " ledr"}, 64'(bus.ledr), 64'(exp_ledr()));
    check_val({name, " seg"}, dut_seg(), exp_seg());
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(logic [10:0] f, int first, int last);
    for (int i = first; i <= last; i++) begin
      bus.ps2_data = f[i];
      bus.ps2_clk  = 1'b1;
      cyc(2);
      bus.ps2_clk  = 1'b0;
      cyc(2);
    end
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_code(logic [7:0] c, bit bad);
    send_bits(mk_frame(c, bad), 0, 10);
    cyc(8);
    model_apply(c, bad);
  endtask

  task automatic reset_and_check(string name);
    resetn = 1'b0;
    cyc(3);
    check_val({name, " in-reset seg"}, dut_seg(), 64'hFFFF_FFFF_FFFF_FFFF);
    check_val({name, " in-reset ledr"}, 64'(bus.ledr), 64'h0);
    resetn = 1'b1;
    cyc(3);
    model_reset();
    check_val({name, " after-reset seg"}, dut_seg(), 64'hFFFF_0303_FFFF_FFFF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [10];
    logic [10:0] f;
    logic [7:0]  c;
    int          r;

    vecs[0] = '{8'h1C, 1'b0, 16'h011C, 64'hFFFF_039F_999F_9F63};
    vecs[1] = '{8'hF0, 1'b0, 16'h011C, 64'hFFFF_039F_999F_9F63};
    vecs[2] = '{8'h1C, 1'b0, 16'h001C, 64'hFFFF_039F_FFFF_FFFF};
    vecs[3] = '{8'h45, 1'b0, 16'h0145, 64'hFFFF_0325_0D03_9949};
    vecs[4] = '{8'h45, 1'b0, 16'h0145, 64'hFFFF_0325_0D03_9949};
    vecs[5] = '{8'h45, 1'b0, 16'h0145, 64'hFFFF_0325_0D03_9949};
    vecs[6] = '{8'hE0, 1'b0, 16'h0145, 64'hFFFF_0325_0D03_9949};
    vecs[7] = '{8'h75, 1'b0, 16'h0375, 64'hFFFF_030D_FFFF_1F49};
    vecs[8] = '{8'h1C, 1'b1, 16'h0775, 64'hFFFF_030D_FFFF_1F49};
    vecs[9] = '{8'h32, 1'b0, 16'h0532, 64'hFFFF_0399_9925_0D25};

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    resetn       = 1'b0;
    cyc(2);
    reset_and_check("power-on");

    for (int i = 0; i < 10; i++) begin
      send_code(vecs[i].code, vecs[i].bad);
      check_val($sformatf("vec%0d ledr", i), 64'(bus.ledr), 64'(vecs[i].ledr));
      check_val($sformatf("vec%0d seg", i), dut_seg(), vecs[i].seg);
    end

    // Reset while bit 4 of a frame is on the line drops the partial frame.
    f = mk_frame(8'h1C, 1'b0);
    send_bits(f, 0, 3);
    bus.ps2_data = f[4];
    reset_and_check("mid-frame");
    bus.ps2_data = 1'b1;
    send_code(8'h1C, 1'b0);
    check_model("post mid-frame reset");

    // Stalled partial frame is abandoned after the idle timeout, without an error.
    reset_and_check("timeout");
    send_bits(mk_frame(8'h1C, 1'b0), 0, 4);
    cyc(TO + 10);
    send_code(8'h16, 1'b0);
    check_val("timeout ledr", 64'(bus.ledr), 64'h0116);
    check_val("timeout seg", dut_seg(), 64'hFFFF_039F_0D9F_9F41);

    // A pause shorter than the timeout must not break a frame.
    f = mk_frame(8'h45, 1'b0);
    send_bits(f, 0, 4);
    cyc(TO - 20);
    send_bits(f, 5, 10);
    cyc(8);
    model_apply(8'h45, 1'b0);
    check_model("slow frame");

    // Randomized key streams against the model.
    reset_and_check("random");
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      c = 8'hE0;
      else if (r < 4) c = 8'hF0;
      else            c = rnd_pool[$urandom_range(0, 7)];
      send_code(c, ($urandom_range(0, 15) == 0));
      check_model($sformatf("random%0d code %h", i, c));
    end

    // Counter wraps after 256 released presses.
    reset_and_check("wrap");
    for (int k = 0; k < 256; k++) begin
      c = key_code[k % 36];
      send_code(c, 1'b0);
      send_code(8'hF0, 1'b0);
      send_code(c, 1'b0);
      if (k == 254) check_val("count FF", 64'(dut_seg() >> 32) & 64'hFFFF, 64'h7171);
    end
    check_val("count wrap 00", 64'(dut_seg() >> 32) & 64'hFFFF, 64'h0303);
    check_model("after wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
